// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Decoupled instruction-fetch front end. It issues word-aligned fetch requests
// to an instruction memory that can have several requests in flight. Responses
// come back in request order and go into a small prefetch FIFO of (pc, instr)
// pairs. Decode pulls from that FIFO with a valid/ready handshake. A redirect
// from branch/jump resolution flushes the FIFO and restarts fetch at a new PC.
// Responses that are still in flight when a redirect happens are counted and
// dropped when they arrive.
//
// Credit scheme: a request is only issued when (outstanding + fifo_count) is
// below FIFO_DEPTH. Every accepted request therefore already owns a FIFO slot,
// so the response path never needs back-pressure.
//
// Parameters
//   XLEN            address width in bits (instructions are always 32 bits)
//   RESET_PC        fetch PC loaded on reset
//   FIFO_DEPTH      prefetch FIFO entries (power of 2, >= 2)
//   MAX_OUTSTANDING max issued-but-unanswered memory requests (>= 1)
//
// Ports
//   clk               clock, rising edge
//   rst_n             synchronous active-low reset
//   imem_req_valid    out  fetch request valid
//   imem_req_ready    in   memory accepts the request this cycle
//   imem_req_addr     out  word-aligned byte address of the request
//   imem_rsp_valid    in   in-order response valid, never back-pressured
//   imem_rsp_data     in   instruction word of the response
//   redirect_valid    in   flush and restart fetch at redirect_pc
//   redirect_pc       in   new fetch PC, bits [1:0] ignored
//   instr_valid       out  FIFO head valid
//   instr_ready       in   decode consumes the head
//   instr_data        out  head instruction (0 when empty)
//   instr_pc          out  head PC (0 when empty)
//   instr_pc_plus_4   out  head PC + 4 modulo 2^XLEN (0 when empty)
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned     XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = {XLEN{1'b0}},
   parameter int unsigned     FIFO_DEPTH      = 4,
   parameter int unsigned     MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr_data,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_pc_plus_4
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   // Wide enough to hold outstanding + fifo_count without overflow.
   localparam int unsigned SW = ((CW > FW) ? CW : FW) + 1;

   localparam logic [CW-1:0]   MAX_OUT_C = CW'(MAX_OUTSTANDING);
   localparam logic [SW-1:0]   DEPTH_C   = SW'(FIFO_DEPTH);
   localparam logic [XLEN-1:0] FOUR_C    = XLEN'(4);
   localparam logic [CW-1:0]   CNT_ONE_C = CW'(1);
   localparam logic [FW-1:0]   FIFO_ONE_C = FW'(1);
   localparam logic [PW-1:0]   PTR_ONE_C = PW'(1);

   // Architectural state
   logic [XLEN-1:0] fetch_pc_r;
   logic [XLEN-1:0] rsp_pc_r;
   logic [CW-1:0]   outstanding_r;
   logic [CW-1:0]   discard_r;
   logic [FW-1:0]   fifo_count_r;
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [XLEN-1:0] pc_mem_r   [FIFO_DEPTH];
   logic [31:0]     data_mem_r [FIFO_DEPTH];

   // Combinational control
   logic [SW-1:0]   credit_used_s;
   logic            req_valid_s;
   logic            accept_s;
   logic            head_valid_s;
   logic            rsp_drop_s;
   logic            push_s;
   logic            pop_s;
   logic [XLEN-1:0] redirect_base_s;
   logic [CW-1:0]   outstanding_nxt_s;
   logic [CW-1:0]   discard_nxt_s;
   logic [FW-1:0]   fifo_count_nxt_s;
   logic            redirect_unused_s;

   // The two low redirect bits are dropped by design.
   assign redirect_unused_s = ^redirect_pc[1:0];

   // Issue, response and handshake qualification.
   always_comb begin
      credit_used_s   = SW'(outstanding_r) + SW'(fifo_count_r);
      // rst_n gating keeps the request low while reset is held.
      req_valid_s     = rst_n && !redirect_valid
                        && (outstanding_r < MAX_OUT_C)
                        && (credit_used_s < DEPTH_C);
      accept_s        = req_valid_s && imem_req_ready;
      head_valid_s    = (fifo_count_r != {FW{1'b0}});
      // A response arriving with a redirect belongs to the old stream.
      rsp_drop_s      = imem_rsp_valid
                        && ((discard_r != {CW{1'b0}}) || redirect_valid);
      push_s          = imem_rsp_valid && !rsp_drop_s;
      pop_s           = head_valid_s && instr_ready && !redirect_valid;
      redirect_base_s = {redirect_pc[XLEN-1:2], 2'b00};
   end

   // Next values of the in-flight counter and the discard counter.
   always_comb begin
      outstanding_nxt_s = outstanding_r;
      discard_nxt_s     = discard_r;
      if (accept_s && !imem_rsp_valid) begin
         outstanding_nxt_s = outstanding_r + CNT_ONE_C;
      end else if (!accept_s && imem_rsp_valid) begin
         outstanding_nxt_s = outstanding_r - CNT_ONE_C;
      end else begin
         outstanding_nxt_s = outstanding_r;
      end
      // After a redirect everything still in flight is stale.
      if (redirect_valid) begin
         discard_nxt_s = outstanding_nxt_s;
      end else if (imem_rsp_valid && (discard_r != {CW{1'b0}})) begin
         discard_nxt_s = discard_r - CNT_ONE_C;
      end else begin
         discard_nxt_s = discard_r;
      end
   end

   // Next FIFO occupancy; a redirect empties the FIFO.
   always_comb begin
      fifo_count_nxt_s = fifo_count_r;
      if (redirect_valid) begin
         fifo_count_nxt_s = {FW{1'b0}};
      end else if (push_s && !pop_s) begin
         fifo_count_nxt_s = fifo_count_r + FIFO_ONE_C;
      end else if (!push_s && pop_s) begin
         fifo_count_nxt_s = fifo_count_r - FIFO_ONE_C;
      end else begin
         fifo_count_nxt_s = fifo_count_r;
      end
   end

   // PC, counter and pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_r    <= RESET_PC;
         rsp_pc_r      <= RESET_PC;
         outstanding_r <= {CW{1'b0}};
         discard_r     <= {CW{1'b0}};
         fifo_count_r  <= {FW{1'b0}};
         wr_ptr_r      <= {PW{1'b0}};
         rd_ptr_r      <= {PW{1'b0}};
      end else begin
         outstanding_r <= outstanding_nxt_s;
         discard_r     <= discard_nxt_s;
         fifo_count_r  <= fifo_count_nxt_s;
         if (redirect_valid) begin
            fetch_pc_r <= redirect_base_s;
            rsp_pc_r   <= redirect_base_s;
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
         end else begin
            if (accept_s) begin
               fetch_pc_r <= fetch_pc_r + FOUR_C;
            end
            if (push_s) begin
               rsp_pc_r <= rsp_pc_r + FOUR_C;
               wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
         end
      end
   end

   // FIFO storage; entries are only read while counted valid, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         pc_mem_r[wr_ptr_r]   <= rsp_pc_r;
         data_mem_r[wr_ptr_r] <= imem_rsp_data;
      end
   end

   // Head presentation; fields read as zero while the FIFO is empty.
   always_comb begin
      instr_data      = 32'h0000_0000;
      instr_pc        = {XLEN{1'b0}};
      instr_pc_plus_4 = {XLEN{1'b0}};
      if (head_valid_s) begin
         instr_data      = data_mem_r[rd_ptr_r];
         instr_pc        = pc_mem_r[rd_ptr_r];
         instr_pc_plus_4 = pc_mem_r[rd_ptr_r] + FOUR_C;
      end else begin
         instr_data      = 32'h0000_0000;
         instr_pc        = {XLEN{1'b0}};
         instr_pc_plus_4 = {XLEN{1'b0}};
      end
   end

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = fetch_pc_r;
   assign instr_valid    = head_valid_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit. A driver process plays the memory and
// decode sides, a model process tracks requests in flight and the expected
// instruction stream as plain queues, and a monitor process compares the DUT
// outputs with the expected stream.
module tb_fetch_unit;
   localparam int          DEPTH = 4;
   localparam int          MAXO  = 2;
   localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid, instr_ready;
   logic [31:0] instr_data, instr_pc, instr_pc_plus_4;

   fetch_unit #(.XLEN(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc), .instr_pc_plus_4(instr_pc_plus_4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      int          due;
      bit          stale;
   } flight_t;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   flight_t     inflight[$];   // accepted requests awaiting a response
   exp_t        exp_q[$];      // instructions decode should see, in order
   logic [31:0] m_fetch_pc;
   int          cyc = 0;
   int          last_due = 0;
   bit          mon_en = 1'b0;
   bit          was_reset = 1'b0;
   bit          s_acc = 1'b0;
   int          tests = 0;
   int          fails = 0;

   // stimulus knobs
   int          lat_lo = 1, lat_hi = 1;
   int          p_rdy = 100, p_ird = 100, p_redir = 0;
   int          redir_mode = 0;
   bit          req_redir = 1'b0;
   logic [31:0] redir_target = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Driver: memory responses, handshakes and redirects, applied at negedge.
   initial begin
      forever begin
         @(negedge clk);
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inflight[0].data;
         end
         imem_req_ready = ($urandom_range(99) < p_rdy);
         instr_ready    = ($urandom_range(99) < p_ird);
         redirect_valid = 1'b0;
         redirect_pc    = $urandom;
         if (req_redir && rst_n) begin
            if (redir_mode == 0 ||
                (redir_mode == 1 && inflight.size() == MAXO) ||
                (redir_mode == 2 && imem_rsp_valid && inflight.size() == MAXO && exp_q.size() > 0)) begin
               redirect_valid = 1'b1;
               redirect_pc    = redir_target;
               instr_ready    = 1'b1;
               req_redir      = 1'b0;
            end
         end else if (p_redir > 0 && $urandom_range(99) < p_redir) begin
            redirect_valid = 1'b1;
         end
      end
   end

   // Monitor: compare outputs with the expected stream, mid-cycle.
   initial begin
      bit exp_rv;
      forever begin
         @(negedge clk);
         #2;
         s_acc = 1'b0;
         if (mon_en) begin
            exp_rv = rst_n && !redirect_valid && (inflight.size() < MAXO)
                     && (inflight.size() + exp_q.size() < DEPTH);
            chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
            if (exp_rv && imem_req_valid) chk("req_addr", imem_req_addr, m_fetch_pc);
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_q.size() != 0});
            if (instr_valid && exp_q.size() > 0) begin
               chk("instr_data", instr_data, exp_q[0].data);
               chk("instr_pc", instr_pc, exp_q[0].pc);
               chk("instr_pc_plus_4", instr_pc_plus_4, exp_q[0].pc + 32'd4);
            end
            if (was_reset) begin
               chk("rst_addr", imem_req_addr, RPC);
               chk("rst_data", instr_data, 32'd0);
               chk("rst_pc", instr_pc, 32'd0);
               chk("rst_pc4", instr_pc_plus_4, 32'd0);
            end
            if (rst_n && instr_valid && instr_ready && !redirect_valid && exp_q.size() > 0)
               void'(exp_q.pop_front());
            s_acc = imem_req_valid && imem_req_ready;
         end
      end
   end

   // Model: request/response bookkeeping at the clock edge.
   initial begin
      flight_t f;
      int      due;
      forever begin
         @(posedge clk);
         if (rst_n !== 1'b1) begin
            inflight.delete();
            exp_q.delete();
            m_fetch_pc = RPC;
            last_due   = 0;
            was_reset  = 1'b1;
            mon_en     = 1'b1;
         end else begin
            was_reset = 1'b0;
            if (imem_rsp_valid && inflight.size() > 0) begin
               f = inflight.pop_front();
               if (!f.stale && !redirect_valid) begin
                  chk("fifo_room", {31'd0, exp_q.size() < DEPTH}, 32'd1);
                  exp_q.push_back('{pc: f.pc, data: f.data});
               end
            end
            if (s_acc) begin
               due = cyc + $urandom_range(lat_hi, lat_lo);
               if (due < last_due) due = last_due;
               last_due = due;
               inflight.push_back('{pc: m_fetch_pc, data: $urandom, due: due, stale: 1'b0});
               m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (redirect_valid) begin
               foreach (inflight[i]) inflight[i].stale = 1'b1;
               exp_q.delete();
               m_fetch_pc = {redirect_pc[31:2], 2'b00};
            end
         end
         cyc++;
      end
   end

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic do_redirect(input int mode, input logic [31:0] tgt);
      redir_mode   = mode;
      redir_target = tgt;
      req_redir    = 1'b1;
      for (int i = 0; i < 300 && req_redir; i++) run(1);
      tests++;
      if (req_redir) begin
         fails++;
         $display("FAIL redirect_wait: got pending expected fired (mode %0d)", mode);
         req_redir = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
      redirect_valid = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b0;
      run(3);
      rst_n = 1'b1;
      run(20);                          // streaming across the 2^32 wrap
      do_redirect(0, 32'h0000_0000);    // restart at 0x0
      run(10);
      p_ird = 0;  run(15);              // FIFO fills, requests stop
      p_ird = 100; run(15);
      p_rdy = 50; run(40);              // stalled requests
      p_rdy = 100;
      lat_lo = 3; lat_hi = 3;
      do_redirect(1, 32'h0000_0103);    // two in flight when redirecting
      run(20);
      p_ird = 50;
      do_redirect(2, 32'h0000_0200);    // redirect with response and pop
      p_ird = 100;
      run(20);
      lat_lo = 1; lat_hi = 4; p_rdy = 70; p_ird = 60; p_redir = 5;
      run(800);                         // randomized mix
      p_redir = 0; p_rdy = 100; p_ird = 100; lat_lo = 1; lat_hi = 1;
      run(5);
      rst_n = 1'b0;                     // reset mid-stream
      run(2);
      rst_n = 1'b1;
      run(20);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
